link_msg_scheduler: RTL and testbench

- Sits between the snake game logic and the uart core; owns that core's wr_uart/w_data and rd_uart/r_data interface.
- TX side: collects three message sources (collision, direction, click), holds one pending message per source, and issues bytes into the UART TX FIFO by fixed priority, spacing bytes by a minimum gap.
- RX side: pops received bytes one at a time, decodes the 2-bit opcode, and emits single-cycle event pulses with their payloads to the game logic.

---
 rtl/link_msg_scheduler.sv | 158 +++++++++++++++
 tb/tb_link_msg_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_msg_scheduler.sv
// Message scheduler between the snake game logic and a UART core: arbitrates three
// TX message sources into the TX FIFO with a minimum byte gap, and decodes RX bytes into event pulses.
module link_msg_scheduler #(
    parameter int GAP_CYCLES = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dir_req,
    input  logic [5:0]       dir_payload,
    input  logic             col_req,
    input  logic [5:0]       col_payload,
    input  logic             clk_req,
    input  logic [5:0]       clk_payload,
    output logic             dir_grant,
    output logic             col_grant,
    output logic             clk_grant,
    input  logic             tx_full,
    output logic             wr_uart,
    output logic [7:0]       w_data,
    input  logic             rx_empty,
    input  logic [7:0]       r_data,
    output logic             rd_uart,
    output logic             rx_dir,
    output logic             rx_col,
    output logic             rx_clk,
    output logic [5:0]       rx_payload,
    output logic [ERR_W-1:0] rx_err_cnt
);

    localparam logic [1:0] OP_ERR = 2'b00;
    localparam logic [1:0] OP_DIR = 2'b01;
    localparam logic [1:0] OP_COL = 2'b10;
    localparam logic [1:0] OP_CLK = 2'b11;

    localparam int CNT_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {TX_IDLE, TX_WRITE, TX_GAP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_POP, RX_SETTLE} rx_state_t;

    tx_state_t  tx_state, tx_next;
    rx_state_t  rx_state, rx_next;
    logic [CNT_W-1:0] gap_cnt;
    logic [1:0] sel_op;

    logic       pend_dir, pend_col, pend_clk;
    logic [5:0] pay_dir, pay_col, pay_clk;

    logic       pick_valid;
    logic [1:0] pick_op;
    logic [5:0] pick_payload;

    // A request arriving in the same cycle counts as pending, so an idle link writes on the next cycle.
    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        pick_valid   = 1'b0;
        pick_op      = OP_ERR;
        pick_payload = 6'd0;
        if (pend_col || col_req) begin
            pick_valid   = 1'b1;
            pick_op      = OP_COL;
            pick_payload = col_req ? col_payload : pay_col;
        end else if (pend_dir || dir_req) begin
            pick_valid   = 1'b1;
            pick_op      = OP_DIR;
            pick_payload = dir_req ? dir_payload : pay_dir;
        end else if (pend_clk || clk_req) begin
            pick_valid   = 1'b1;
            pick_op      = OP_CLK;
            pick_payload = clk_req ? clk_payload : pay_clk;
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (pick_valid && !tx_full) tx_next = TX_WRITE;
            TX_WRITE: tx_next = (GAP_CYCLES == 0) ? TX_IDLE : TX_GAP;
            TX_GAP:   if (gap_cnt == CNT_W'(GAP_LAST)) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    assign wr_uart   = (tx_state == TX_WRITE);
    assign col_grant = wr_uart && (sel_op == OP_COL);
    assign dir_grant = wr_uart && (sel_op == OP_DIR);
    assign clk_grant = wr_uart && (sel_op == OP_CLK);

    // NOTE: state uses non-blocking assignments and an async active-low reset so every flop clears at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            gap_cnt  <= '0;
            sel_op   <= OP_ERR;
            w_data   <= 8'd0;
            pend_dir <= 1'b0;
            pend_col <= 1'b0;
            pend_clk <= 1'b0;
            pay_dir  <= 6'd0;
            pay_col  <= 6'd0;
            pay_clk  <= 6'd0;
        end else begin
            tx_state <= tx_next;
            if (tx_state == TX_WRITE)
                gap_cnt <= '0;
            else if (tx_state == TX_GAP)
                gap_cnt <= gap_cnt + CNT_W'(1);
            if (tx_state == TX_IDLE && tx_next == TX_WRITE) begin
                sel_op <= pick_op;
                w_data <= {pick_op, pick_payload};
            end
            // A request in its own grant cycle re-arms the pending flag instead of being dropped.
            pend_dir <= dir_req || (pend_dir && !dir_grant);
            pend_col <= col_req || (pend_col && !col_grant);
            pend_clk <= clk_req || (pend_clk && !clk_grant);
            if (dir_req) pay_dir <= dir_payload;
            if (col_req) pay_col <= col_payload;
            if (clk_req) pay_clk <= clk_payload;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (!rx_empty) rx_next = RX_POP;
            RX_POP:    rx_next = RX_SETTLE;
            RX_SETTLE: rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    assign rd_uart = (rx_state == RX_POP);

    // Decode happens on the pop edge, so event pulses land in the settle cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= RX_IDLE;
            rx_dir     <= 1'b0;
            rx_col     <= 1'b0;
            rx_clk     <= 1'b0;
            rx_payload <= 6'd0;
            rx_err_cnt <= '0;
        end else begin
            rx_state <= rx_next;
            rx_dir   <= rd_uart && (r_data[7:6] == OP_DIR);
            rx_col   <= rd_uart && (r_data[7:6] == OP_COL);
            rx_clk   <= rd_uart && (r_data[7:6] == OP_CLK);
            if (rd_uart) begin
                if (r_data[7:6] != OP_ERR)
                    rx_payload <= r_data[5:0];
                else if (rx_err_cnt != {ERR_W{1'b1}})
                    rx_err_cnt <= rx_err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_link_msg_scheduler.sv
// Directed bench for link_msg_scheduler: a cycle table for TX arbitration/gap/back-pressure,
// plus hand sequences for RX decode, error saturation, grant-cycle re-request and mid-gap reset.
module tb_link_msg_scheduler;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       dir_req, col_req, clk_req;
    logic [5:0] dir_payload, col_payload, clk_payload;
    logic       dir_grant, col_grant, clk_grant;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       rx_dir, rx_col, rx_clk;
    logic [5:0] rx_payload;
    logic [7:0] rx_err_cnt;

    link_msg_scheduler #(.GAP_CYCLES(GAP), .ERR_W(8)) dut (
        .clk(clk), .rst(rst),
        .dir_req(dir_req), .dir_payload(dir_payload),
        .col_req(col_req), .col_payload(col_payload),
        .clk_req(clk_req), .clk_payload(clk_payload),
        .dir_grant(dir_grant), .col_grant(col_grant), .clk_grant(clk_grant),
        .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .rx_dir(rx_dir), .rx_col(rx_col), .rx_clk(rx_clk),
        .rx_payload(rx_payload), .rx_err_cnt(rx_err_cnt)
    );

    always #5 clk = ~clk;

    logic [2:0]  grants;
    logic [11:0] tx_outs;
    logic [29:0] all_outs;
    assign grants   = {col_grant, dir_grant, clk_grant};
    assign tx_outs  = {wr_uart, w_data, grants};
    assign all_outs = {wr_uart, w_data, grants, rd_uart, rx_dir, rx_col, rx_clk, rx_payload, rx_err_cnt};

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // RX FIFO model: a pop seen in one cycle takes effect at the following falling edge.
    logic [7:0] rx_q[$];
    logic       pop_flag;
    initial begin
        rx_empty = 1'b1;
        r_data   = 8'h00;
        pop_flag = 1'b0;
        forever begin
            @(negedge clk);
            if (pop_flag && rx_q.size() > 0) rx_q.delete(0);
            pop_flag = rd_uart;
            rx_empty = (rx_q.size() == 0);
            r_data   = rx_empty ? 8'h00 : rx_q[0];
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [5:0] pay;
        logic       after_pop;
    } ev_t;
    ev_t ev_q[$];
    int  rd_times[$];
    logic prev_rd;
    initial begin
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_dir || rx_col || rx_clk)
                ev_q.push_back('{op: {rx_col | rx_clk, rx_dir | rx_clk}, pay: rx_payload, after_pop: prev_rd});
            prev_rd = rd_uart;
            if (rd_uart) rd_times.push_back(cyc);
        end
    end

    function automatic logic [8:0] ev_word(input int i);
        if (i >= ev_q.size()) return 9'h1FF;
        return {ev_q[i].op, ev_q[i].pay, ev_q[i].after_pop};
    endfunction

    task automatic wait_rx(input string name, input int budget);
        int n = 0;
        while ((rx_q.size() != 0 || pop_flag) && n < budget) begin
            tick();
            n++;
        end
        idle(4);
        check(name, 32'(rx_q.size()), 32'd0);
    endtask

    task automatic get_write(input string name, input logic [7:0] exp_d, input logic [2:0] exp_g,
                             output int t);
        int n = 0;
        while (!wr_uart && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(tx_outs), 32'({1'b1, exp_d, exp_g}));
        t = cyc;
    endtask

    task automatic clear_reqs();
        dir_req = 1'b0;
        col_req = 1'b0;
        clk_req = 1'b0;
    endtask

    typedef struct {
        logic       dir_req;
        logic [5:0] dir_pay;
        logic       col_req;
        logic [5:0] col_pay;
        logic       clk_req;
        logic [5:0] clk_pay;
        logic       tx_full;
        logic       exp_wr;
        logic [7:0] exp_data;
        logic [2:0] exp_grant;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1, t2, wr_cnt;

        // Each row: inputs held across one rising edge, expected TX outputs just after it.
        vecs[0]  = '{1'b1, 6'h02, 1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b1, 8'h42, 3'b010};
        vecs[1]  = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b1, 6'h05, 1'b0, 1'b0, 8'h42, 3'b000};
        vecs[2]  = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 8'h42, 3'b000};
        vecs[3]  = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 8'h42, 3'b000};
        vecs[4]  = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 8'h42, 3'b000};
        vecs[5]  = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 8'h42, 3'b000};
        vecs[6]  = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b1, 8'hC5, 3'b001};
        vecs[7]  = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 8'hC5, 3'b000};
        vecs[8]  = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 8'hC5, 3'b000};
        vecs[9]  = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 8'hC5, 3'b000};
        vecs[10] = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 8'hC5, 3'b000};
        vecs[11] = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 8'hC5, 3'b000};
        vecs[12] = '{1'b0, 6'h00, 1'b1, 6'h11, 1'b0, 6'h00, 1'b1, 1'b0, 8'hC5, 3'b000};
        vecs[13] = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 6'h00, 1'b1, 1'b0, 8'hC5, 3'b000};
        vecs[14] = '{1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b1, 8'h91, 3'b100};

        rst = 1'b0;
        clear_reqs();
        dir_payload = 6'h00;
        col_payload = 6'h00;
        clk_payload = 6'h00;
        tx_full     = 1'b0;
        idle(2);
        check("reset_outputs", 32'(all_outs), 32'd0);
        rst = 1'b1;
        idle(2);

        for (int i = 0; i < 15; i++) begin
            dir_req     = vecs[i].dir_req;
            dir_payload = vecs[i].dir_pay;
            col_req     = vecs[i].col_req;
            col_payload = vecs[i].col_pay;
            clk_req     = vecs[i].clk_req;
            clk_payload = vecs[i].clk_pay;
            tx_full     = vecs[i].tx_full;
            tick();
            check($sformatf("tx_vec%0d", i), 32'(tx_outs),
                  32'({vecs[i].exp_wr, vecs[i].exp_data, vecs[i].exp_grant}));
        end
        clear_reqs();
        tx_full = 1'b0;
        idle(8);

        // Three simultaneous requests drain in priority order with the gap between them.
        col_req = 1'b1; col_payload = 6'h01;
        dir_req = 1'b1; dir_payload = 6'h03;
        clk_req = 1'b1; clk_payload = 6'h05;
        tick();
        clear_reqs();
        get_write("prio_col", 8'h81, 3'b100, t0);
        tick();
        get_write("prio_dir", 8'h43, 3'b010, t1);
        tick();
        get_write("prio_clk", 8'hC5, 3'b001, t2);
        check("prio_space1", 32'((t1 - t0) >= GAP + 1), 32'd1);
        check("prio_space2", 32'((t2 - t1) >= GAP + 1), 32'd1);
        idle(8);

        // Back-pressure: newest direction payload wins once the FIFO has room.
        tx_full = 1'b1;
        wr_cnt  = 0;
        dir_req = 1'b1; dir_payload = 6'h01;
        tick();
        dir_req = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (wr_uart) wr_cnt++;
            if (i == 4) begin dir_req = 1'b1; dir_payload = 6'h04; end
            tick();
            dir_req = 1'b0;
        end
        if (wr_uart) wr_cnt++;
        check("full_hold_no_write", 32'(wr_cnt), 32'd0);
        tx_full = 1'b0;
        tick();
        check("full_release", 32'(tx_outs), 32'({1'b1, 8'h44, 3'b010}));
        wr_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (wr_uart) wr_cnt++;
        end
        check("full_single_send", 32'(wr_cnt), 32'd0);

        // Request for the granted source during its grant cycle is kept.
        col_req = 1'b1; col_payload = 6'h06;
        tick();
        check("regrant_first", 32'(tx_outs), 32'({1'b1, 8'h86, 3'b100}));
        col_payload = 6'h07;
        tick();
        clear_reqs();
        get_write("regrant_second", 8'h87, 3'b100, t0);
        idle(8);

        // RX: direction then error byte.
        rd_times.delete();
        ev_q.delete();
        rx_q.push_back(8'h43);
        rx_q.push_back(8'h00);
        wait_rx("rx1_drain", 40);
        check("rx1_pops", 32'(rd_times.size()), 32'd2);
        check("rx1_pop_space", 32'(rd_times.size() == 2 && (rd_times[1] - rd_times[0]) >= 3), 32'd1);
        check("rx1_events", 32'(ev_q.size()), 32'd1);
        check("rx1_dir_event", 32'(ev_word(0)), 32'({2'b01, 6'h03, 1'b1}));
        check("rx1_err_cnt", 32'(rx_err_cnt), 32'd1);
        check("rx1_payload", 32'(rx_payload), 32'h03);

        // RX: collision, error with non-zero payload, click.
        rd_times.delete();
        ev_q.delete();
        rx_q.push_back(8'h85);
        rx_q.push_back(8'h3F);
        rx_q.push_back(8'hFE);
        wait_rx("rx2_drain", 40);
        check("rx2_pops", 32'(rd_times.size()), 32'd3);
        check("rx2_events", 32'(ev_q.size()), 32'd2);
        check("rx2_col_event", 32'(ev_word(0)), 32'({2'b10, 6'h05, 1'b1}));
        check("rx2_clk_event", 32'(ev_word(1)), 32'({2'b11, 6'h3E, 1'b1}));
        check("rx2_err_cnt", 32'(rx_err_cnt), 32'd2);
        check("rx2_payload", 32'(rx_payload), 32'h3E);

        // RX: error counter saturation.
        for (int i = 0; i < 300; i++) rx_q.push_back(8'h00);
        wait_rx("rx_sat_drain", 1200);
        check("rx_sat_err_cnt", 32'(rx_err_cnt), 32'd255);
        check("rx_sat_payload", 32'(rx_payload), 32'h3E);

        // Reset in the gap with a collision re-armed during its grant cycle.
        col_req = 1'b1; col_payload = 6'h0A;
        tick();
        check("rst_pre_grant", 32'(tx_outs), 32'({1'b1, 8'h8A, 3'b100}));
        col_payload = 6'h0B;
        tick();
        clear_reqs();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_outputs", 32'(all_outs), 32'd0);
        tick();
        rst = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (wr_uart) wr_cnt++;
        end
        check("rst_pending_dropped", 32'(wr_cnt), 32'd0);
        dir_req = 1'b1; dir_payload = 6'h15;
        tick();
        clear_reqs();
        check("rst_after_new_req", 32'(tx_outs), 32'({1'b1, 8'h55, 3'b010}));
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
